// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// State/owner encodings and the latched access bundle.
package dmem_arbiter_pkg;
  localparam int WORD = 32;

  typedef enum logic [1:0] {
    DA_IDLE   = 2'd0,
    DA_ACCESS = 2'd1,
    DA_RESP   = 2'd2
  } da_state_t;

  typedef enum logic {
    DA_OWN_CPU = 1'b0,
    DA_OWN_DBG = 1'b1
  } da_owner_t;

  typedef struct packed {
    da_owner_t       owner;
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
  } da_req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and memory buses of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic            cpu_req;
  logic            cpu_we;
  logic [WORD-1:0] cpu_addr;
  logic [WORD-1:0] cpu_wdata;
  logic [WORD-1:0] cpu_rdata;
  logic            cpu_ack;
  logic            cpu_stall;
  logic            dbg_req;
  logic            dbg_we;
  logic [WORD-1:0] dbg_addr;
  logic [WORD-1:0] dbg_wdata;
  logic [WORD-1:0] dbg_rdata;
  logic            dbg_ack;
  logic            mem_en;
  logic            mem_we;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Arbitration policy: CPU priority with debug anti-starvation.
// Pure combinational so the policy can be tested on its own.
module dmem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic [3:0] starve,
  output logic       grant_dbg
);
  logic starved;

  assign starved   = starve >= 4'(STARVE_LIMIT);
  assign grant_dbg = dbg_req & (~cpu_req | starved);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between CPU MEM stage and debug port.
// IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (ack) -> IDLE.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  da_state_t       state;
  da_state_t       state_nx;
  da_req_t         lat;
  logic [3:0]      cnt;
  logic [3:0]      starve;
  logic [WORD-1:0] cpu_rd;
  logic [WORD-1:0] dbg_rd;
  logic            grant_dbg;
  logic            any_req;
  logic            last;
  logic            en;
  logic            we;
  logic            cack;
  logic            dack;

  assign any_req = bus.cpu_req | bus.dbg_req;
  assign last    = cnt == 4'(MEM_LATENCY - 1);

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .cpu_req  (bus.cpu_req),
    .dbg_req  (bus.dbg_req),
    .starve   (starve),
    .grant_dbg(grant_dbg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DA_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DA_IDLE:   if (any_req) state_nx = DA_ACCESS;
      DA_ACCESS: if (last) state_nx = DA_RESP;
      DA_RESP:   state_nx = DA_IDLE;
      default:   state_nx = DA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat    <= '0;
      cnt    <= '0;
      starve <= '0;
      cpu_rd <= '0;
      dbg_rd <= '0;
    end else begin
      if (state == DA_IDLE) begin
        cnt <= '0;
        if (any_req) begin
          lat.owner <= da_owner_t'(grant_dbg);
          lat.we    <= grant_dbg ? bus.dbg_we : bus.cpu_we;
          lat.addr  <= grant_dbg ? bus.dbg_addr : bus.cpu_addr;
          lat.wdata <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
        // a losing debug request implies the CPU also requested
        if (!bus.dbg_req || grant_dbg) starve <= '0;
        else if (starve != 4'hF)       starve <= starve + 4'd1;
      end
      if (state == DA_ACCESS) begin
        cnt <= cnt + 4'd1;
        if (last) begin
          if (lat.owner == DA_OWN_DBG) dbg_rd <= bus.mem_rdata;
          else                         cpu_rd <= bus.mem_rdata;
        end
      end
    end
  end

  always_comb begin
    en   = 1'b0;
    we   = 1'b0;
    cack = 1'b0;
    dack = 1'b0;
    unique case (state)
      DA_ACCESS: begin
        en = 1'b1;
        we = last & lat.we;
      end
      DA_RESP: begin
        cack = lat.owner == DA_OWN_CPU;
        dack = lat.owner == DA_OWN_DBG;
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = en;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = lat.addr;
  assign bus.mem_wdata = lat.wdata;
  assign bus.cpu_ack   = cack;
  assign bus.dbg_ack   = dack;
  assign bus.cpu_rdata = cpu_rd;
  assign bus.dbg_rdata = dbg_rd;
  assign bus.cpu_stall = bus.cpu_req & ~cack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: two arbiters (latency 1 and 3) on word memories.
// Expected acks are queued by stimulus and checked by monitors.
module tb_dmem_arbiter;
  typedef struct {
    bit          dbg;
    bit          cmp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  dmem_arbiter_if b1();
  dmem_arbiter_if b3();

  dmem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
    .clk(clk), .reset(rst1), .bus(b1));
  dmem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_l3 (
    .clk(clk), .reset(rst3), .bus(b3));

  exp_t        q1[$];
  exp_t        q3[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          we1 = 0;
  int          we3 = 0;
  logic [31:0] mem1[0:63];
  logic [31:0] mem3[0:63];

  assign b1.mem_rdata = mem1[b1.mem_addr[7:2]];
  assign b3.mem_rdata = mem3[b3.mem_addr[7:2]];

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 32'd0;
        mem3[i] <= 32'd0;
      end
      mem1[3] <= 32'd45;
      mem1[4] <= 32'd77;
      mem3[2] <= 32'h0000_1111;
    end else begin
      if (b1.mem_en && b1.mem_we) begin
        mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
        we1 <= we1 + 1;
      end
      if (b3.mem_en && b3.mem_we) begin
        mem3[b3.mem_addr[7:2]] <= b3.mem_wdata;
        we3 <= we3 + 1;
      end
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.cpu_ack || b1.dbg_ack) begin
      if (q1.size() == 0) begin
        check("l1 unexpected ack",
              {30'b0, b1.dbg_ack, b1.cpu_ack}, 32'd0);
      end else begin
        e = q1.pop_front();
        check("l1 ack port", {30'b0, b1.dbg_ack, b1.cpu_ack},
              e.dbg ? 32'd2 : 32'd1);
        if (e.cmp)
          check("l1 rdata", e.dbg ? b1.dbg_rdata : b1.cpu_rdata,
                e.data);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (b3.cpu_ack || b3.dbg_ack) begin
      if (q3.size() == 0) begin
        check("l3 unexpected ack",
              {30'b0, b3.dbg_ack, b3.cpu_ack}, 32'd0);
      end else begin
        e = q3.pop_front();
        check("l3 ack port", {30'b0, b3.dbg_ack, b3.cpu_ack},
              e.dbg ? 32'd2 : 32'd1);
        if (e.cmp)
          check("l3 rdata", e.dbg ? b3.dbg_rdata : b3.cpu_rdata,
                e.data);
      end
    end
  end

  task automatic go1(input bit dbg, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output int n, output int stalls);
    @(posedge clk);
    #1;
    if (dbg) begin
      b1.dbg_req = 1'b1; b1.dbg_we = we;
      b1.dbg_addr = addr; b1.dbg_wdata = wd;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_we = we;
      b1.cpu_addr = addr; b1.cpu_wdata = wd;
    end
    n = 0;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (b1.cpu_stall) stalls++;
      if (dbg ? b1.dbg_ack : b1.cpu_ack) break;
    end
    b1.cpu_req = 1'b0;
    b1.dbg_req = 1'b0;
  endtask

  task automatic go3(input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, output int n,
                     output int en, output int we_n,
                     output int we_at);
    @(posedge clk);
    #1;
    b3.cpu_req = 1'b1; b3.cpu_we = we;
    b3.cpu_addr = addr; b3.cpu_wdata = wd;
    n = 0; en = 0; we_n = 0; we_at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (b3.mem_en) begin
        en++;
        check("l3 mem_addr", b3.mem_addr, addr);
      end
      if (b3.mem_we) begin
        we_n++;
        we_at = en;
        check("l3 mem_wdata", b3.mem_wdata, wd);
      end
      if (b3.cpu_ack) break;
    end
    b3.cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, en, wn, wa, w, k;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = 0; b1.dbg_wdata = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.dbg_req = 0; b3.dbg_we = 0; b3.dbg_addr = 0; b3.dbg_wdata = 0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    check("rst cpu_ack", {31'b0, b1.cpu_ack}, 32'd0);
    check("rst dbg_ack", {31'b0, b1.dbg_ack}, 32'd0);
    check("rst mem_en", {31'b0, b1.mem_en}, 32'd0);
    check("rst mem_we", {31'b0, b1.mem_we}, 32'd0);
    check("rst cpu_rdata", b1.cpu_rdata, 32'd0);
    check("rst mem_addr", b1.mem_addr, 32'd0);

    q1.push_back('{dbg: 1'b0, cmp: 1'b1, data: 32'd45});
    go1(1'b0, 1'b0, 32'd12, 32'd0, n, s);
    check("l1 read latency", n, 32'd3);
    check("l1 read stall cycles", s, 32'd2);
    repeat (2) @(negedge clk);
    check("l1 rdata hold", b1.cpu_rdata, 32'd45);

    w = we1;
    q1.push_back('{dbg: 1'b1, cmp: 1'b0, data: 32'd0});
    go1(1'b1, 1'b1, 32'd12, 32'd10, n, s);
    check("l1 dbg write strobes", we1 - w, 32'd1);
    check("l1 dbg write stall", s, 32'd0);
    q1.push_back('{dbg: 1'b0, cmp: 1'b1, data: 32'd10});
    go1(1'b0, 1'b0, 32'd12, 32'd0, n, s);
    q1.push_back('{dbg: 1'b1, cmp: 1'b1, data: 32'd77});
    go1(1'b1, 1'b0, 32'd16, 32'd0, n, s);

    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 5; j++)
        q1.push_back('{dbg: (j == 4), cmp: 1'b1,
                       data: (j == 4) ? 32'd77 : 32'd10});
    @(posedge clk);
    #1;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'd12;
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b0; b1.dbg_addr = 32'd16;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b1.cpu_ack || b1.dbg_ack) k++;
      if (k == 10) break;
    end
    b1.cpu_req = 1'b0;
    b1.dbg_req = 1'b0;
    check("l1 contention acks", k, 32'd10);

    q1.push_back('{dbg: 1'b0, cmp: 1'b1, data: 32'd10});
    q1.push_back('{dbg: 1'b1, cmp: 1'b1, data: 32'd77});
    @(posedge clk);
    #1;
    b1.cpu_req = 1'b1; b1.cpu_addr = 32'd12;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b1.mem_en) break;
    end
    b1.cpu_req = 1'b0;
    b1.dbg_req = 1'b1; b1.dbg_addr = 32'd16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b1.cpu_ack) break;
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k++;
      if (b1.dbg_ack) break;
    end
    b1.dbg_req = 1'b0;
    check("l1 dbg after drop latency", k, 32'd3);

    w = we3;
    q3.push_back('{dbg: 1'b0, cmp: 1'b0, data: 32'd0});
    go3(1'b1, 32'd8, 32'hA5A5_0001, n, en, wn, wa);
    check("l3 store mem_en cycles", en, 32'd3);
    check("l3 store we pulses", wn, 32'd1);
    check("l3 store we on cycle", wa, 32'd3);
    check("l3 store ack latency", n, 32'd5);
    check("l3 store strobes", we3 - w, 32'd1);
    check("l3 stored word", mem3[2], 32'hA5A5_0001);

    w = we3;
    @(posedge clk);
    #1;
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b1;
    b3.cpu_addr = 32'd20; b3.cpu_wdata = 32'h0000_DEAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b3.mem_en) break;
    end
    @(negedge clk);
    check("l3 second access cycle", {31'b0, b3.mem_en}, 32'd1);
    rst3 = 1'b1;
    b3.cpu_req = 1'b0;
    #1;
    check("l3 rst mem_en", {31'b0, b3.mem_en}, 32'd0);
    check("l3 rst mem_we", {31'b0, b3.mem_we}, 32'd0);
    check("l3 rst cpu_ack", {31'b0, b3.cpu_ack}, 32'd0);
    check("l3 rst mem_addr", b3.mem_addr, 32'd0);
    check("l3 rst cpu_rdata", b3.cpu_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst3 = 1'b0;
    check("l3 rst no strobe", we3 - w, 32'd0);
    check("l3 rst word kept", mem3[5], 32'd0);

    q3.push_back('{dbg: 1'b0, cmp: 1'b1, data: 32'hA5A5_0001});
    go3(1'b0, 32'd8, 32'd0, n, en, wn, wa);
    check("l3 read after rst latency", n, 32'd5);
    check("l3 read no strobe", wn, 32'd0);

    repeat (3) @(negedge clk);
    check("l1 acks outstanding", q1.size(), 32'd0);
    check("l3 acks outstanding", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipelined CPU's MEM-stage data port and a debug/loader port.
- The debug/loader port lets benches and a future loader preload and inspect memory words without hierarchical pokes.
- Sequences each access over a fixed, configurable memory latency and returns read data with a one-cycle ack.
- Produces the CPU stall that freezes the pipeline while the CPU's access is pending or the debug port holds the memory.

Parameters:
- MEM_LATENCY, 1: cycles the memory port is held enabled per access (legal range 1..15).
- STARVE_LIMIT, 4: consecutive lost arbitrations after which the debug port wins over the CPU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  1 = store word, 0 = load word
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data; valid while cpu_ack=1
- cpu_ack  output  1  one-cycle completion pulse
- cpu_stall  output  1  combinational: cpu_req & ~cpu_ack
- dbg_req  input  1  debug request; held until dbg_ack
- dbg_we  input  1  debug write enable
- dbg_addr  input  32  byte address
- dbg_wdata  input  32  write data
- dbg_rdata  output  32  read data; valid while dbg_ack=1
- dbg_ack  output  1  one-cycle completion pulse
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write strobe
- mem_addr  output  32  byte address to memory
- mem_wdata  output  32  data to memory
- mem_rdata  input  32  memory read data

Behaviour:
- Reset: all registered outputs go to 0; state=IDLE, owner=CPU, starve count=0. If reset asserts mid-access, the access is abandoned, no ack is issued, and no write strobe occurs after reset asserts.
- States:
  - IDLE -> ACCESS on any request.
  - ACCESS holds for MEM_LATENCY cycles -> RESP.
  - RESP lasts one cycle -> IDLE.
- Arbitration happens in IDLE only:
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless starve count >= STARVE_LIMIT; then debug wins.
  - Starve count increments, saturating at 15, each time the debug port requests and loses. It clears when debug is granted or when dbg_req=0 in IDLE.
- On grant, latch owner, we, addr and wdata. Later changes on the request inputs do not affect the in-flight access.
- ACCESS:
  - mem_en=1 and mem_addr/mem_wdata are driven from the latched values for every ACCESS cycle.
  - mem_we=1 only on the final ACCESS cycle: exactly one write strobe per store.
  - On the final cycle, mem_rdata is captured into the owner's rdata register. For stores, that register captures mem_rdata as well; its value is don't-care.
- RESP: the owner's ack=1 for exactly one cycle with rdata valid; the other ack stays 0. mem_en=0.
- Timing: a request sampled in IDLE at edge N gives ack high after edge N+MEM_LATENCY+1, for a throughput of one access per MEM_LATENCY+2 cycles.
- A request dropped mid-access: the access still completes and the ack still pulses; the requester ignores it.
- Back-to-back requests: a request still high in the cycle after its ack is treated as a new access.
- The rdata registers hold their last value outside ack.
- Addresses pass through unmodified. Word alignment is the memory's responsibility.
- cpu_stall is combinational and has no registered delay.

Decomposition:
- Shared constants header (alongside ISA.v/Debug.v):
  - state encodings DA_IDLE, DA_ACCESS, DA_RESP (2 bits)
  - owner encodings DA_OWN_CPU=0, DA_OWN_DBG=1
  - reuse of the existing WORD width macro
- Sub-module dmem_arb_pick: combinational priority/starvation decision (inputs cpu_req, dbg_req, starve count; output grant_dbg). This keeps the policy unit-testable.
- The FSM, latency counter and latches stay in dmem_arbiter.

Test Plan:
- CPU read, MEM_LATENCY=1, memory word 3 = 45: cpu_req, cpu_we=0, cpu_addr=12 -> cpu_ack pulses once, 2 cycles after the request edge. cpu_rdata=45; cpu_stall=1 for exactly 2 cycles.
- Debug preload then CPU read: dbg write of 10 to addr 12, then CPU reads addr 12 -> exactly one mem_we pulse and dbg_ack once. cpu_rdata=10.
- Contention, STARVE_LIMIT=4: cpu_req and dbg_req held high continuously -> grants are CPU, CPU, CPU, CPU, DBG, then repeat. The debug port never waits more than 5 accesses.
- MEM_LATENCY=3 store: mem_en high for 3 cycles, with mem_we only on the third. Ack follows 1 cycle later, 4 cycles after grant.
- Reset asserted during the second ACCESS cycle of a store -> no mem_we and no ack. All outputs read 0 immediately (asynchronous). After release, the next request is served normally.
- Requester drops cpu_req mid-access: the access completes and cpu_ack still pulses once. The arbiter returns to IDLE and grants a pending dbg_req next cycle.
